// File: rtl/nano_mem_pkg.sv
// Shared types for the NanoCore line-memory responder: line container,
// responder FSM encoding and the kind of write a WR pass is serving.
package nano_mem_pkg;

  localparam int LINE_WORDS = 8;

  typedef logic [LINE_WORDS-1:0][31:0] line_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    DRAIN = 3'd3,
    UPD   = 3'd4,
    RESP  = 3'd5
  } resp_state_e;

  typedef enum logic {
    REQ_MISS_WR = 1'b0,
    REQ_WB      = 1'b1
  } req_kind_e;

endpackage

// File: rtl/nano_line_mem_responder_if.sv
// Cache-side miss/write-back bus. The cache is the master; the memory
// responder is the slave.
interface nano_line_mem_responder_if;
  import nano_mem_pkg::*;

  logic        i_miss_rden;
  logic        i_miss_wren;
  logic        i_wb_wren;
  logic [31:0] i_miss_addr;
  line_t       i_miss_wdata;
  logic        o_miss_resp;
  logic        o_wb_gnt;
  logic        o_upd_valid;
  line_t       o_upd_rdata;

  modport master (
    output i_miss_rden, i_miss_wren, i_wb_wren, i_miss_addr, i_miss_wdata,
    input  o_miss_resp, o_wb_gnt, o_upd_valid, o_upd_rdata
  );

  modport slave (
    input  i_miss_rden, i_miss_wren, i_wb_wren, i_miss_addr, i_miss_wdata,
    output o_miss_resp, o_wb_gnt, o_upd_valid, o_upd_rdata
  );

endinterface

// File: rtl/nano_line_fwd_buf.sv
// Single-entry buffer holding the last line written to SRAM, so a read of
// that line can be answered without an SRAM pass (NANO_MEM_LINE_FWD_EN builds).
module nano_line_fwd_buf
  import nano_mem_pkg::*;
#(
  parameter int TAG_W = 11
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  line_t            i_wr_data,
  input  logic [TAG_W-1:0] i_lookup_tag,
  output logic             o_match,
  output line_t            o_data
);

  logic             valid_q;
  logic [TAG_W-1:0] tag_q;
  line_t            data_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
    end else if (i_wr_en) begin
      valid_q <= 1'b1;
      tag_q   <= i_wr_tag;
    end
  end

  // NOTE: the payload is storage, not control -- valid_q gates every use,
  // so it is left out of reset and keeps a plain enable-only flop bank.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) data_q <= i_wr_data;
  end

  assign o_match = valid_q && (tag_q == i_lookup_tag);
  assign o_data  = data_q;

endmodule

// File: rtl/nano_line_mem_responder.sv
// Line-granular memory responder: serialises 8-word cache lines onto a 32-bit
// single-port SRAM. Define NANO_MEM_LINE_FWD_EN to forward the last written line.
module nano_line_mem_responder
  import nano_mem_pkg::*;
#(
  parameter int SRAM_AW = 14,
  parameter int RD_LAT  = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  nano_line_mem_responder_if.slave  cache,
  output logic                      o_sram_rden,
  output logic                      o_sram_wren,
  output logic [SRAM_AW-1:0]        o_sram_addr,
  output logic [31:0]               o_sram_wdata,
  input  logic [31:0]               i_sram_rdata
);

  localparam int LINE_AW = SRAM_AW - 3;

  localparam logic [2:0] ST_IDLE  = IDLE;
  localparam logic [2:0] ST_WR    = WR;
  localparam logic [2:0] ST_RD    = RD;
  localparam logic [2:0] ST_DRAIN = DRAIN;
  localparam logic [2:0] ST_UPD   = UPD;
  localparam logic [2:0] ST_RESP  = RESP;

  logic [2:0]         state_q, state_d;
  req_kind_e          kind_q, kind_d;
  logic [LINE_AW-1:0] line_q, line_d;
  line_t              data_q, data_d;
  logic [2:0]         beat_q, beat_d;
  logic [3:0]         ret_q, ret_d;
  logic [RD_LAT-1:0]  vld_q;
  line_t              upd_rdata_q, upd_rdata_d;

  logic               fwd_hit;
  line_t              fwd_data;
  logic               unused_addr_hi;

  assign unused_addr_hi = ^cache.i_miss_addr[31:LINE_AW];

`ifdef NANO_MEM_LINE_FWD_EN
  logic wr_last;
  assign wr_last = (state_q == ST_WR) && (beat_q == 3'd7);

  nano_line_fwd_buf #(.TAG_W(LINE_AW)) u_fwd_buf (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_wr_en      (wr_last),
    .i_wr_tag     (line_q),
    .i_wr_data    (data_q),
    .i_lookup_tag (line_q),
    .o_match      (fwd_hit),
    .o_data       (fwd_data)
  );
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  // NOTE: every signal this block drives gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    line_d       = line_q;
    data_d       = data_q;
    beat_d       = beat_q;
    ret_d        = ret_q;
    upd_rdata_d  = upd_rdata_q;
    o_sram_rden  = 1'b0;
    o_sram_wren  = 1'b0;
    o_sram_addr  = '0;
    o_sram_wdata = '0;
    cache.o_miss_resp = 1'b0;
    cache.o_wb_gnt    = 1'b0;
    cache.o_upd_valid = 1'b0;

    // Returning read words land in order, one per valid-shift pop.
    if (vld_q[RD_LAT-1]) begin
      data_d[ret_q[2:0]] = i_sram_rdata;
      ret_d              = ret_q + 4'd1;
    end

    case (state_q)
      ST_IDLE: begin
        beat_d = '0;
        ret_d  = '0;
        if (cache.i_miss_wren) begin
          state_d = ST_WR;
          kind_d  = REQ_MISS_WR;
          line_d  = cache.i_miss_addr[LINE_AW-1:0];
          data_d  = cache.i_miss_wdata;
        end else if (cache.i_miss_rden) begin
          state_d = ST_RD;
          line_d  = cache.i_miss_addr[LINE_AW-1:0];
        end else if (cache.i_wb_wren) begin
          state_d = ST_WR;
          kind_d  = REQ_WB;
          line_d  = cache.i_miss_addr[LINE_AW-1:0];
          data_d  = cache.i_miss_wdata;
        end
      end
      ST_WR: begin
        o_sram_wren  = 1'b1;
        o_sram_addr  = {line_q, beat_q};
        o_sram_wdata = data_q[beat_q];
        beat_d       = beat_q + 3'd1;
        if (beat_q == 3'd7) state_d = ST_RESP;
      end
      ST_RESP: begin
        cache.o_miss_resp = (kind_q == REQ_MISS_WR);
        cache.o_wb_gnt    = (kind_q == REQ_WB);
        state_d           = ST_IDLE;
      end
      ST_RD: begin
        cache.o_miss_resp = (beat_q == 3'd0);
        if (fwd_hit) begin
          state_d     = ST_UPD;
          upd_rdata_d = fwd_data;
        end else begin
          o_sram_rden = 1'b1;
          o_sram_addr = {line_q, beat_q};
          beat_d      = beat_q + 3'd1;
          if (beat_q == 3'd7) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (ret_q == 4'(LINE_WORDS)) begin
          state_d     = ST_UPD;
          upd_rdata_d = data_q;
        end
      end
      ST_UPD: begin
        cache.o_upd_valid = 1'b1;
        state_d           = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      kind_q      <= REQ_MISS_WR;
      line_q      <= '0;
      data_q      <= '0;
      beat_q      <= '0;
      ret_q       <= '0;
      vld_q       <= '0;
      upd_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      line_q      <= line_d;
      data_q      <= data_d;
      beat_q      <= beat_d;
      ret_q       <= ret_d;
      upd_rdata_q <= upd_rdata_d;
      vld_q[0]    <= o_sram_rden;
      for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  assign cache.o_upd_rdata = upd_rdata_q;

endmodule
